// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: one memory port shared between speculative loads
// from Execute and committed stores drained from an in-order store FIFO.
// Issues at most one access per cycle and returns load data one cycle later,
// tagged with the ROB entry of the load.
module dmem_port_arbiter #(
    parameter int DATA       = 32,
    parameter int ADDR       = 8,
    parameter int SB_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_req,
    input  logic [ADDR-1:0]             ld_addr,
    input  logic [2:0]                  ld_load,
    input  logic [6:0]                  ld_tag,
    output logic                        ld_gnt,
    input  logic                        st_req,
    input  logic [ADDR-1:0]             st_addr,
    input  logic [DATA-1:0]             st_data,
    input  logic [1:0]                  st_store,
    output logic                        st_acc,
    input  logic                        drain_all,
    output logic                        mem_we,
    output logic [ADDR-1:0]             mem_addr,
    output logic [DATA-1:0]             mem_wd,
    output logic [1:0]                  mem_store,
    output logic [2:0]                  mem_load,
    input  logic [DATA-1:0]             mem_rd,
    output logic                        ld_valid,
    output logic [DATA-1:0]             ld_data,
    output logic [6:0]                  ld_tag_out,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_empty
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);
    localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

    // Store FIFO storage (data only, never reset: validity comes from the pointers)
    logic [ADDR-1:0] sb_addr_q [SB_DEPTH];
    logic [DATA-1:0] sb_data_q [SB_DEPTH];
    logic [1:0]      sb_size_q [SB_DEPTH];

    // Control state
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          ld_valid_q;
    logic [6:0]    ld_tag_q;

    // Decision signals
    logic          fifo_empty;
    logic          fifo_full;
    logic          raw_hit;
    logic          issue_ld;
    logic          issue_st;
    logic [PW-1:0] slot_off;

    // RAW detection: a live FIFO entry in the same 32-bit word as the load
    always_comb begin
        raw_hit  = 1'b0;
        slot_off = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if (({1'b0, slot_off} < count_q) &&
                (sb_addr_q[i][ADDR-1:2] == ld_addr[ADDR-1:2])) begin
                raw_hit = 1'b1;
            end
        end
    end

    // Issue decision: a non-empty FIFO drains whenever the load cannot go
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        issue_ld   = 1'b0;
        issue_st   = 1'b0;
        if (fifo_empty) begin
            issue_ld = ld_req;
        end else begin
            issue_ld = ld_req & ~drain_all & ~raw_hit & ~fifo_full & (starve_q != SMAX_C);
            issue_st = ~issue_ld;
        end
    end

    // Memory port and handshake outputs; an idle port drives all zeros
    always_comb begin
        mem_we    = issue_st;
        mem_addr  = '0;
        mem_wd    = '0;
        mem_store = '0;
        mem_load  = '0;
        if (issue_st) begin
            mem_addr  = sb_addr_q[rd_ptr_q];
            mem_wd    = sb_data_q[rd_ptr_q];
            mem_store = sb_size_q[rd_ptr_q];
        end else if (issue_ld) begin
            mem_addr  = ld_addr;
            mem_load  = ld_load;
        end
        ld_gnt = issue_ld;
        // A full FIFO always drains, so the freed slot can be reused the same cycle
        st_acc = st_req & ((count_q < DEPTH_C) | issue_st);
    end

    // Next-state for pointers, occupancy and starvation counter
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(st_acc);
        rd_ptr_d = rd_ptr_q + PW'(issue_st);
        count_d  = count_q + CW'(st_acc) - CW'(issue_st);
        if (fifo_empty || issue_st) begin
            starve_d = '0;
        end else if (issue_ld && (starve_q != SMAX_C)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            ld_valid_q <= 1'b0;
            ld_tag_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            ld_valid_q <= issue_ld;
            if (issue_ld) begin
                ld_tag_q <= ld_tag;
            end
        end
    end

    // FIFO write port: accepted stores land at the tail
    always_ff @(posedge clk) begin
        if (st_acc) begin
            sb_addr_q[wr_ptr_q] <= st_addr;
            sb_data_q[wr_ptr_q] <= st_data;
            sb_size_q[wr_ptr_q] <= st_store;
        end
    end

    // Load return: memory read data arrives the cycle after issue and is passed through
    assign ld_valid   = ld_valid_q;
    assign ld_data    = ld_valid_q ? mem_rd : '0;
    assign ld_tag_out = ld_tag_q;
    assign sb_count   = count_q;
    assign sb_empty   = fifo_empty;

endmodule
